if_id_stage: RTL and testbench

Pipeline register between instruction fetch and decode for the single-clock execution-cycle core. It captures the fetched instruction and its two PC values on each clock, holds them under stall, and turns them into a bubble under flush. It drives the fetch stage's PC write-enable and presents registered instruction fields and precomputed targets to the decode/execute logic. A saturating stall counter provides basic performance visibility.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/instr_field_decode.sv | 40 ++++
 rtl/if_id_stage.sv | 113 +++++++++++
 tb/tb_if_id_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the IF/ID pipeline register and its field decoder.
// Holds the IF/ID state type, the NOP encoding, instruction field bit
// positions, the IF/ID payload struct and a 16-bit sign-extension helper.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  // Instruction field bit positions
  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned RS_HI     = 25;
  localparam int unsigned RS_LO     = 21;
  localparam int unsigned RT_HI     = 20;
  localparam int unsigned RT_LO     = 16;
  localparam int unsigned RD_HI     = 15;
  localparam int unsigned RD_LO     = 11;
  localparam int unsigned SHAMT_HI  = 10;
  localparam int unsigned SHAMT_LO  = 6;
  localparam int unsigned FUNCT_HI  = 5;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned JADDR_HI  = 25;
  localparam int unsigned JADDR_LO  = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } ifid_state_e;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_payload_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN - 16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field slicing, immediate sign extension and branch/jump
// target computation from the registered instruction and its PC+4.
// Ports:
//   instr_i          registered instruction
//   pc_plus4_i       registered PC+4 of that instruction
//   opcode_o..funct_o instruction fields
//   imm_sext_o       sign-extended 16-bit immediate
//   branch_target_o  pc_plus4 + (imm_sext << 2), wraps modulo 2^32
//   jump_target_o    {pc_plus4[31:28], instr[25:0], 2'b00}
module instr_field_decode
  import core_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [5:0]      opcode_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      shamt_o,
  output logic [5:0]      funct_o,
  output logic [XLEN-1:0] imm_sext_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic [XLEN-1:0] jump_target_o
);

  assign opcode_o = instr_i[OPCODE_HI:OPCODE_LO];
  assign rs_o     = instr_i[RS_HI:RS_LO];
  assign rt_o     = instr_i[RT_HI:RT_LO];
  assign rd_o     = instr_i[RD_HI:RD_LO];
  assign shamt_o  = instr_i[SHAMT_HI:SHAMT_LO];
  assign funct_o  = instr_i[FUNCT_HI:FUNCT_LO];

  assign imm_sext_o = sext16(instr_i[IMM_HI:IMM_LO]);

  // Word offset: the top two bits of the immediate fall off the shift
  assign branch_target_o = pc_plus4_i + {imm_sext_o[XLEN-3:0], 2'b00};

  assign jump_target_o = {pc_plus4_i[XLEN-1:XLEN-4], instr_i[JADDR_HI:JADDR_LO], 2'b00};

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched instruction and its PCs,
// holds them under stall, turns them into a bubble under flush, drives the
// fetch PC write-enable and presents decoded fields and branch/jump targets.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instruction_in, pc_current_in, pc_next_in, fetch_valid   fetch outputs
//   stall, flush      hazard controls (flush wins over stall)
//   pc_write_en       combinational fetch PC write-enable
//   instruction_out, pc_out, pc_plus4_out, valid_out         registered values
//   opcode..funct, imm_sext, branch_target, jump_target      derived from regs
//   stall_count       saturating count of stalled cycles
// Only WIDTH = 32 is supported.
module if_id_stage
  import core_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [XLEN-1:0] NOP         = NOP_INSTR,
  parameter int unsigned     STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       instruction_in,
  input  logic [WIDTH-1:0]       pc_current_in,
  input  logic [WIDTH-1:0]       pc_next_in,
  input  logic                   fetch_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   pc_write_en,
  output logic [WIDTH-1:0]       instruction_out,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       pc_plus4_out,
  output logic                   valid_out,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [WIDTH-1:0]       imm_sext,
  output logic [WIDTH-1:0]       branch_target,
  output logic [WIDTH-1:0]       jump_target,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam ifid_payload_t BUBBLE = '{instr: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};

  ifid_payload_t               reg_q, reg_d;
  ifid_state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0]      scnt_q, scnt_d;

  // Stateless on purpose: fetch feeds back through this path
  assign pc_write_en = !stall || flush;

  // Next-state: flush > stall > load; illegal encodings recover to a bubble
  always_comb begin
    reg_d   = reg_q;
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_EMPTY, ST_RUN, ST_HOLD: begin
        if (flush) begin
          reg_d   = BUBBLE;
          state_d = ST_EMPTY;
        end else if (stall) begin
          state_d = ST_HOLD;
          if (scnt_q != '1) scnt_d = scnt_q + STALL_CNT_W'(1);
        end else begin
          reg_d   = '{instr: instruction_in, pc: pc_current_in,
                      pc_plus4: pc_next_in, valid: fetch_valid};
          state_d = fetch_valid ? ST_RUN : ST_EMPTY;
        end
      end
      default: begin
        reg_d   = BUBBLE;
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, payload and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q   <= BUBBLE;
      state_q <= ST_EMPTY;
      scnt_q  <= '0;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  assign instruction_out = reg_q.instr;
  assign pc_out          = reg_q.pc;
  assign pc_plus4_out    = reg_q.pc_plus4;
  assign valid_out       = reg_q.valid;
  assign stall_count     = scnt_q;

  instr_field_decode u_decode (
    .instr_i         (reg_q.instr),
    .pc_plus4_i      (reg_q.pc_plus4),
    .opcode_o        (opcode),
    .rs_o            (rs),
    .rt_o            (rt),
    .rd_o            (rd),
    .shamt_o         (shamt),
    .funct_o         (funct),
    .imm_sext_o      (imm_sext),
    .branch_target_o (branch_target),
    .jump_target_o   (jump_target)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: table of load vectors with
// hand-computed decode results, plus stall/flush/saturation/reset sequences.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_in, pc_current_in, pc_next_in;
  logic        fetch_valid, stall, flush;
  logic        pc_write_en;
  logic [31:0] instruction_out, pc_out, pc_plus4_out;
  logic        valid_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, branch_target, jump_target;
  logic [7:0]  stall_count;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk             (clk),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .pc_current_in   (pc_current_in),
    .pc_next_in      (pc_next_in),
    .fetch_valid     (fetch_valid),
    .stall           (stall),
    .flush           (flush),
    .pc_write_en     (pc_write_en),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .valid_out       (valid_out),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .shamt           (shamt),
    .funct           (funct),
    .imm_sext        (imm_sext),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .stall_count     (stall_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc, pc4;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm, bt, jt;
    logic [7:0]  scnt;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, pcn;
    logic        fv;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[6];

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic fv,
                              input logic [5:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                              input logic [4:0] rd_v, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [31:0] imm, input logic [31:0] bt, input logic [31:0] jt);
    vec_t v;
    v.instr = ins; v.pc = pc; v.pcn = pc + 32'd4; v.fv = fv;
    v.e.valid = fv; v.e.instr = ins; v.e.pc = pc; v.e.pc4 = pc + 32'd4;
    v.e.op = op; v.e.rs = rs_v; v.e.rt = rt_v; v.e.rd = rd_v; v.e.sh = sh; v.e.fn = fn;
    v.e.imm = imm; v.e.bt = bt; v.e.jt = jt; v.e.scnt = 8'd0;
    return v;
  endfunction

  function automatic exp_t bubble(input logic [7:0] sc);
    exp_t e;
    e.valid = 1'b0; e.instr = 32'h0; e.pc = 32'h0; e.pc4 = 32'h0;
    e.op = 6'h0; e.fn = 6'h0; e.rs = 5'h0; e.rt = 5'h0; e.rd = 5'h0; e.sh = 5'h0;
    e.imm = 32'h0; e.bt = 32'h0; e.jt = 32'h0; e.scnt = sc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e, input string tag);
    chk({tag, ".valid"},  32'(valid_out),       32'(e.valid));
    chk({tag, ".instr"},  instruction_out,      e.instr);
    chk({tag, ".pc"},     pc_out,               e.pc);
    chk({tag, ".pc4"},    pc_plus4_out,         e.pc4);
    chk({tag, ".opcode"}, 32'(opcode),          32'(e.op));
    chk({tag, ".rs"},     32'(rs),              32'(e.rs));
    chk({tag, ".rt"},     32'(rt),              32'(e.rt));
    chk({tag, ".rd"},     32'(rd),              32'(e.rd));
    chk({tag, ".shamt"},  32'(shamt),           32'(e.sh));
    chk({tag, ".funct"},  32'(funct),           32'(e.fn));
    chk({tag, ".imm"},    imm_sext,             e.imm);
    chk({tag, ".btgt"},   branch_target,        e.bt);
    chk({tag, ".jtgt"},   jump_target,          e.jt);
    chk({tag, ".scnt"},   32'(stall_count),     32'(e.scnt));
  endtask

  // Drive one cycle, push the expectation, compare once the edge has passed
  task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pcn,
                       input logic fv, input logic st, input logic fl,
                       input exp_t e, input string tag);
    exp_t got;
    @(negedge clk);
    instruction_in = ins; pc_current_in = pc; pc_next_in = pcn;
    fetch_valid = fv; stall = st; flush = fl;
    exp_q.push_back(e);
    #1 chk({tag, ".pc_we"}, 32'(pc_write_en), 32'(!st || fl));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard actual=empty required=entry", tag);
    end else begin
      got = exp_q.pop_front();
      check_all(got, tag);
    end
  endtask

  task automatic load_vec(input int i, input string tag);
    exp_t e;
    e = vecs[i].e;
    e.scnt = cur.scnt;
    cur = e;
    apply(vecs[i].instr, vecs[i].pc, vecs[i].pcn, vecs[i].fv, 1'b0, 1'b0, e, tag);
  endtask

  task automatic stall_step(input string tag);
    exp_t e;
    e = cur;
    if (e.scnt != 8'hFF) e.scnt = e.scnt + 8'd1;
    cur = e;
    apply($urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b0, e, tag);
  endtask

  initial begin
    vecs[0] = mk(32'h2008_0005, 32'h0000_0000, 1'b1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h05,
                 32'h0000_0005, 32'h0000_0018, 32'h0020_0014);
    vecs[1] = mk(32'h1000_FFFF, 32'h0000_00FC, 1'b1, 6'h04, 5'd0, 5'd0, 5'h1F, 5'h1F, 6'h3F,
                 32'hFFFF_FFFF, 32'h0000_00FC, 32'h0003_FFFC);
    vecs[2] = mk(32'h0800_0040, 32'h1000_0000, 1'b1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd1, 6'h00,
                 32'h0000_0040, 32'h1000_0104, 32'h1000_0100);
    vecs[3] = mk(32'h012A_4020, 32'h0000_0040, 1'b1, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20,
                 32'h0000_4020, 32'h0001_00C4, 32'h04A9_0080);
    vecs[4] = mk(32'hFFFF_8000, 32'hFFFF_FFFC, 1'b0, 6'h3F, 5'h1F, 5'h1F, 5'h10, 5'd0, 6'h00,
                 32'hFFFF_8000, 32'hFFFE_0000, 32'h0FFE_0000);
    vecs[5] = mk(32'h1000_7FFF, 32'hFFFF_FFF8, 1'b1, 6'h04, 5'd0, 5'd0, 5'h0F, 5'h1F, 6'h3F,
                 32'h0000_7FFF, 32'h0001_FFF8, 32'hF001_FFFC);

    reset = 1'b1;
    instruction_in = 32'h0; pc_current_in = 32'h0; pc_next_in = 32'h0;
    fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    cur = bubble(8'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all(bubble(8'd0), "reset");
    chk("reset.pc_we", 32'(pc_write_en), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Table of loads
    for (int i = 0; i < 6; i++) load_vec(i, $sformatf("vec%0d", i));

    // Stall three cycles while RUN, then load new inputs
    for (int i = 0; i < 3; i++) stall_step($sformatf("stall3_%0d", i));
    chk("stall3.count", 32'(stall_count), 32'd3);
    load_vec(3, "after_stall");

    // Flush while stalled: bubble, counter unchanged
    stall_step("pre_flush");
    cur = bubble(cur.scnt);
    apply(32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_1004, 1'b1, 1'b1, 1'b1, cur, "flush_stall");

    // Stall in EMPTY keeps the bubble
    stall_step("stall_empty");

    // Saturation
    load_vec(0, "pre_sat");
    for (int i = 0; i < 300; i++) stall_step("sat");
    chk("sat.count", 32'(stall_count), 32'd255);

    // Asynchronous reset between edges
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    instruction_in = 32'h0; pc_current_in = 32'h0; pc_next_in = 32'h0;
    #2 reset = 1'b1;
    #1 check_all(bubble(8'd0), "async_rst");
    chk("async_rst.pc_we", 32'(pc_write_en), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cur = bubble(8'd0);
    apply(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, cur, "no_replay");

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard.leftover actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
